// File: rtl/apb_to_obi_pkg.sv
// Shared types and default widths for the APB-to-OBI bridge.
// Holds the FSM state encoding and the parity helper.
package apb_to_obi_pkg;

   localparam int unsigned APB_AW_DEF  = 32;
   localparam int unsigned APB_DW_DEF  = 32;
   localparam int unsigned OBI_AW_DEF  = 32;
   localparam int unsigned OBI_DW_DEF  = 32;
   localparam int unsigned OBI_IDW_DEF = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RSP,
      ST_DONE
   } state_t;

   // An OBI parity companion is valid when it is the inverse of its signal.
   function automatic logic par_ok(input logic sig, input logic par);
      return par == ~sig;
   endfunction

endpackage

// File: rtl/apb_to_obi_bridge_if.sv
// Bus bundle between an APB requester and an OBI subordinate.
// The slave modport is the bridge's view, master is the environment's view.
interface apb_to_obi_bridge_if
   import apb_to_obi_pkg::*;
#(
   parameter int unsigned APB_AW  = APB_AW_DEF,
   parameter int unsigned APB_DW  = APB_DW_DEF,
   parameter int unsigned OBI_AW  = OBI_AW_DEF,
   parameter int unsigned OBI_DW  = OBI_DW_DEF,
   parameter int unsigned OBI_IDW = OBI_IDW_DEF
);

   logic [APB_AW-1:0]   APB_PADDR;
   logic                APB_PSEL;
   logic                APB_PENABLE;
   logic                APB_PWRITE;
   logic [APB_DW-1:0]   APB_PWDATA;
   logic [APB_DW/8-1:0] APB_PSTRB;
   logic [APB_DW-1:0]   APB_PRDATA;
   logic                APB_PREADY;
   logic                APB_PSLVERR;

   logic                obi_req;
   logic                obi_reqpar;
   logic [OBI_AW-1:0]   obi_addr;
   logic                obi_we;
   logic [OBI_DW/8-1:0] obi_be;
   logic [OBI_DW-1:0]   obi_wdata;
   logic [OBI_IDW-1:0]  obi_aid;
   logic                obi_rready;
   logic                obi_rreadypar;
   logic                obi_gnt;
   logic                obi_gntpar;
   logic                obi_rvalid;
   logic                obi_rvalidpar;
   logic [OBI_DW-1:0]   obi_rdata;
   logic                obi_err;
   logic [OBI_IDW-1:0]  obi_rid;

   modport slave (
      input  APB_PADDR, APB_PSEL, APB_PENABLE, APB_PWRITE, APB_PWDATA, APB_PSTRB,
      output APB_PRDATA, APB_PREADY, APB_PSLVERR,
      output obi_req, obi_reqpar, obi_addr, obi_we, obi_be, obi_wdata, obi_aid,
      output obi_rready, obi_rreadypar,
      input  obi_gnt, obi_gntpar, obi_rvalid, obi_rvalidpar, obi_rdata, obi_err, obi_rid
   );

   modport master (
      output APB_PADDR, APB_PSEL, APB_PENABLE, APB_PWRITE, APB_PWDATA, APB_PSTRB,
      input  APB_PRDATA, APB_PREADY, APB_PSLVERR,
      input  obi_req, obi_reqpar, obi_addr, obi_we, obi_be, obi_wdata, obi_aid,
      input  obi_rready, obi_rreadypar,
      output obi_gnt, obi_gntpar, obi_rvalid, obi_rvalidpar, obi_rdata, obi_err, obi_rid
   );

endinterface

// File: rtl/obi_par_chk.sv
// OBI handshake parity comparator; flags a bad companion bit while its check is armed.
// Only built into the bridge when APB_TO_OBI_PARCHK_EN is defined.
module obi_par_chk
   import apb_to_obi_pkg::*;
(
   input  logic gnt,
   input  logic gntpar,
   input  logic rvalid,
   input  logic rvalidpar,
   input  logic chk_gnt,
   input  logic chk_rvalid,
   output logic bad
);

   always_comb begin
      bad = (chk_gnt    && !par_ok(gnt, gntpar)) ||
            (chk_rvalid && !par_ok(rvalid, rvalidpar));
   end

endmodule

// File: rtl/apb_to_obi_bridge.sv
// APB completer to OBI requester bridge, one outstanding transaction at a time.
// Optional handshake parity checking is enabled with macro APB_TO_OBI_PARCHK_EN.
module apb_to_obi_bridge
   import apb_to_obi_pkg::*;
#(
   parameter int unsigned APB_AW  = APB_AW_DEF,
   parameter int unsigned APB_DW  = APB_DW_DEF,
   parameter int unsigned OBI_AW  = OBI_AW_DEF,
   parameter int unsigned OBI_DW  = OBI_DW_DEF,
   parameter int unsigned OBI_IDW = OBI_IDW_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   apb_to_obi_bridge_if.slave bus
);

   localparam int unsigned BW = OBI_DW / 8;

   state_t            state_q, state_d;
   logic [OBI_AW-1:0] addr_ext;
   logic [OBI_AW-1:0] addr_q;
   logic [OBI_DW-1:0] wdata_q;
   logic [OBI_DW-1:0] rdata_q;
   logic [BW-1:0]     be_q;
   logic              we_q;
   logic              skip_q;
   logic              err_q;
   logic              abort_q;
   logic              par_err_q;
   logic              accept;

   generate
      if (OBI_AW <= APB_AW) begin : g_addr_trunc
         assign addr_ext = bus.APB_PADDR[OBI_AW-1:0];
      end else begin : g_addr_ext
         assign addr_ext = {{(OBI_AW-APB_AW){1'b0}}, bus.APB_PADDR};
      end
   endgenerate

   assign accept = (state_q == ST_IDLE) && bus.APB_PSEL;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Zero-strobe writes still pass through REQ (with obi_req low) so the
   // register stage is uniform; they leave REQ without touching OBI.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.APB_PSEL) state_d = ST_REQ;
         ST_REQ: begin
            if (skip_q)           state_d = ST_DONE;
            else if (bus.obi_gnt) state_d = ST_RSP;
         end
         ST_RSP:  if (bus.obi_rvalid) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         skip_q  <= 1'b0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= addr_ext;
            wdata_q <= bus.APB_PWDATA;
            we_q    <= bus.APB_PWRITE;
            be_q    <= bus.APB_PWRITE ? bus.APB_PSTRB : '1;
            skip_q  <= bus.APB_PWRITE && (bus.APB_PSTRB == '0);
            rdata_q <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
         end
         if (((state_q == ST_REQ) || (state_q == ST_RSP)) && !bus.APB_PSEL)
            abort_q <= 1'b1;
         if ((state_q == ST_RSP) && bus.obi_rvalid) begin
            if (!we_q) rdata_q <= bus.obi_rdata;
            err_q <= bus.obi_err;
         end
      end
   end

`ifdef APB_TO_OBI_PARCHK_EN
   logic par_bad;

   obi_par_chk u_par_chk (
      .gnt        (bus.obi_gnt),
      .gntpar     (bus.obi_gntpar),
      .rvalid     (bus.obi_rvalid),
      .rvalidpar  (bus.obi_rvalidpar),
      .chk_gnt    ((state_q == ST_REQ) && !skip_q),
      .chk_rvalid (state_q == ST_RSP),
      .bad        (par_bad)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     par_err_q <= 1'b0;
      else if (accept)  par_err_q <= 1'b0;
      else if (par_bad) par_err_q <= 1'b1;
   end

   logic unused_in;
   assign unused_in = ^{bus.APB_PENABLE, bus.APB_PADDR, bus.obi_rid};
`else
   assign par_err_q = 1'b0;

   logic unused_in;
   assign unused_in = ^{bus.APB_PENABLE, bus.APB_PADDR, bus.obi_rid,
                        bus.obi_gntpar, bus.obi_rvalidpar};
`endif

   always_comb begin
      bus.obi_req       = (state_q == ST_REQ) && !skip_q;
      bus.obi_reqpar    = !bus.obi_req;
      bus.obi_rready    = (state_q == ST_RSP);
      bus.obi_rreadypar = !bus.obi_rready;
      bus.obi_addr      = addr_q;
      bus.obi_we        = we_q;
      bus.obi_be        = be_q;
      bus.obi_wdata     = wdata_q;
      bus.obi_aid       = '0;
      bus.APB_PREADY    = (state_q == ST_DONE);
      bus.APB_PRDATA    = ((state_q == ST_DONE) && !abort_q) ? rdata_q : '0;
      bus.APB_PSLVERR   = (state_q == ST_DONE) && !abort_q && (err_q || par_err_q);
   end

endmodule

// File: tb/tb_apb_to_obi_bridge.sv
// Self-checking bench for apb_to_obi_bridge: directed cases plus random APB/OBI traffic.
// Expected results come from transaction-level rules, not from the bridge's state.
module tb_apb_to_obi_bridge;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   apb_to_obi_bridge_if bus ();

   apb_to_obi_bridge #(
      .APB_AW  (32),
      .APB_DW  (32),
      .OBI_AW  (32),
      .OBI_DW  (32),
      .OBI_IDW (1)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic idle_obi();
      bus.obi_gnt       = 1'b0;
      bus.obi_gntpar    = 1'b1;
      bus.obi_rvalid    = 1'b0;
      bus.obi_rvalidpar = 1'b1;
      bus.obi_err       = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_prdata"},  bus.APB_PRDATA, 0);
      chk({tag, "_pready"},  bus.APB_PREADY, 0);
      chk({tag, "_pslverr"}, bus.APB_PSLVERR, 0);
      chk({tag, "_req"},     bus.obi_req, 0);
      chk({tag, "_reqpar"},  bus.obi_reqpar, 1);
      chk({tag, "_rready"},  bus.obi_rready, 0);
      chk({tag, "_rrdypar"}, bus.obi_rreadypar, 1);
      chk({tag, "_addr"},    bus.obi_addr, 0);
      chk({tag, "_we"},      bus.obi_we, 0);
      chk({tag, "_be"},      bus.obi_be, 0);
      chk({tag, "_wdata"},   bus.obi_wdata, 0);
      chk({tag, "_aid"},     bus.obi_aid, 0);
   endtask

   // One APB access against a modelled OBI subordinate. gdly: REQ cycles before
   // grant; rdly: RSP cycles before rvalid; drop_at: cycle PSEL is withdrawn (-1 none).
   task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input int gdly, input int rdly, input logic [31:0] rdat,
                       input logic rerr, input int drop_at, input logic bad_gpar);
      int   cyc, reqs, rsps, exp_lat;
      logic done, skip, ab, par_fault;
      logic [3:0] ebe;
      skip = we && (strb == 4'h0);
      ebe  = we ? strb : 4'hF;
      exp_lat = skip ? 2 : gdly + rdly + 3;
`ifdef APB_TO_OBI_PARCHK_EN
      par_fault = bad_gpar && !skip;
`else
      par_fault = 1'b0;
`endif
      @(negedge clk);
      bus.APB_PSEL    = 1'b1;
      bus.APB_PENABLE = 1'b0;
      bus.APB_PADDR   = addr;
      bus.APB_PWRITE  = we;
      bus.APB_PWDATA  = wdata;
      bus.APB_PSTRB   = strb;
      idle_obi();
      cyc = 0; reqs = 0; rsps = 0; done = 1'b0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         bus.APB_PENABLE = bus.APB_PSEL;
         idle_obi();
         chk({tag, "_reqpar"}, bus.obi_reqpar ^ bus.obi_req, 1);
         chk({tag, "_rrdypar"}, bus.obi_rreadypar ^ bus.obi_rready, 1);
         if (bus.obi_req) begin
            chk({tag, "_addr"}, bus.obi_addr, addr);
            chk({tag, "_we"}, bus.obi_we, we);
            chk({tag, "_be"}, bus.obi_be, ebe);
            if (we) chk({tag, "_wdata"}, bus.obi_wdata, wdata);
            if (reqs == gdly) begin
               bus.obi_gnt    = 1'b1;
               bus.obi_gntpar = bad_gpar;
            end
            reqs++;
         end else if (bus.obi_rready) begin
            if (rsps == rdly) begin
               bus.obi_rvalid    = 1'b1;
               bus.obi_rvalidpar = 1'b0;
               bus.obi_rdata     = rdat;
               bus.obi_err       = rerr;
            end
            rsps++;
         end
         if (bus.APB_PREADY) begin
            done = 1'b1;
            ab = (drop_at >= 1) && (drop_at < cyc);
            chk({tag, "_latency"}, cyc, exp_lat);
            chk({tag, "_prdata"}, bus.APB_PRDATA, (!we && !ab && !skip) ? rdat : 32'h0);
            chk({tag, "_pslverr"}, bus.APB_PSLVERR, !ab && ((rerr && !skip) || par_fault));
            bus.APB_PSEL    = 1'b0;
            bus.APB_PENABLE = 1'b0;
         end else if (cyc == drop_at) begin
            bus.APB_PSEL    = 1'b0;
            bus.APB_PENABLE = 1'b0;
         end
      end
      if (!done) chk({tag, "_timeout"}, 0, 1);
      chk({tag, "_req_cycles"}, reqs, skip ? 0 : gdly + 1);
      @(negedge clk);
      idle_obi();
      chk({tag, "_pready_once"}, bus.APB_PREADY, 0);
      chk({tag, "_req_after"}, bus.obi_req, 0);
   endtask

   initial begin
      bus.APB_PADDR   = '0;
      bus.APB_PSEL    = 1'b0;
      bus.APB_PENABLE = 1'b0;
      bus.APB_PWRITE  = 1'b0;
      bus.APB_PWDATA  = '0;
      bus.APB_PSTRB   = '0;
      bus.obi_rdata   = '0;
      bus.obi_rid     = '0;
      idle_obi();
      repeat (3) @(negedge clk);
      chk_reset_outputs("por");
      reset_n = 1'b1;

      xfer("wr_basic", 1'b1, 32'h0105_0010, 32'hA5A5_0001, 4'hF, 0, 0, 32'h0, 1'b0, -1, 1'b0);
      xfer("rd_gnt5",  1'b0, 32'h0000_1234, 32'h0, 4'h0, 5, 0, 32'hDEAD_BEEF, 1'b0, -1, 1'b0);
      xfer("rd_err",   1'b0, 32'h0000_2000, 32'h0, 4'h0, 1, 2, 32'h1357_9BDF, 1'b1, -1, 1'b0);
      xfer("rd_after", 1'b0, 32'h0000_2004, 32'h0, 4'h0, 0, 1, 32'h0BAD_F00D, 1'b0, -1, 1'b0);
      xfer("wr_nostrb",1'b1, 32'h0000_3000, 32'h1111_2222, 4'h0, 0, 0, 32'h0, 1'b0, -1, 1'b0);
      xfer("wr_strb5", 1'b1, 32'h0000_3004, 32'h3333_4444, 4'h5, 2, 1, 32'h0, 1'b0, -1, 1'b0);
      xfer("rd_drop",  1'b0, 32'h0000_4000, 32'h0, 4'h0, 3, 1, 32'hCAFE_0001, 1'b1, 2, 1'b0);
      xfer("wr_gpar",  1'b1, 32'h0000_5000, 32'h5555_AAAA, 4'hF, 1, 0, 32'h0, 1'b0, -1, 1'b1);
      xfer("rd_clean", 1'b0, 32'h0000_5004, 32'h0, 4'h0, 0, 0, 32'h7777_8888, 1'b0, -1, 1'b0);

      // Reset asserted while the bridge waits for a response.
      begin
         bit in_rsp;
         in_rsp = 1'b0;
         @(negedge clk);
         bus.APB_PSEL   = 1'b1;
         bus.APB_PWRITE = 1'b0;
         bus.APB_PADDR  = 32'h0000_6000;
         for (int i = 0; i < 20 && !in_rsp; i++) begin
            @(negedge clk);
            bus.APB_PENABLE = 1'b1;
            in_rsp = bus.obi_rready;
            bus.obi_gnt    = bus.obi_req;
            bus.obi_gntpar = !bus.obi_req;
         end
         chk("rst_reached_rsp", in_rsp, 1);
         idle_obi();
         @(negedge clk);
         reset_n = 1'b0;
         #1;
         chk_reset_outputs("rst_mid");
         @(negedge clk);
         bus.APB_PSEL    = 1'b0;
         bus.APB_PENABLE = 1'b0;
         @(negedge clk);
         reset_n = 1'b1;
      end
      xfer("post_rst", 1'b0, 32'h0000_6004, 32'h0, 4'h0, 1, 1, 32'h2468_ACE0, 1'b0, -1, 1'b0);

      for (int t = 0; t < 40; t++) begin
         logic       rwe, rerr;
         logic [3:0] rstrb;
         int         rdrop;
         rwe   = 1'($urandom_range(0, 1));
         rstrb = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         rerr  = ($urandom_range(0, 3) == 0);
         rdrop = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : -1;
         xfer("rand", rwe, $urandom, $urandom, rstrb,
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              $urandom, rerr, rdrop, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
